// File: rtl/if_fetch_ctrl_pkg.sv
// Shared encodings for the IF fetch controller.
// State codes, control bundle type and fixed output patterns.
package if_fetch_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 32;
  localparam int SEQ_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } fstate_e;

  typedef struct packed {
    logic pc_sel;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctl_t;

  localparam ctl_t C_BOOT  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctl_t C_FETCH = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctl_t C_REDIR = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctl_t C_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctl_t C_HALT  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/if_fetch_ctrl_perf_cnt.sv
// 32-bit event counter: sync active-high clear, count on en, plain wrap.
// Ports: clk, reset, en in; count out.
module if_ctrl_perf_cnt
  import if_fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: PC/IF-IF enables, redirect select, pipeline flushes.
// Ports: clk, reset, branch_taken, load_use_hazard, halt_req in; controls, state, counters out.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = 2,
  parameter int STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic        load_use_hazard,
  input  logic        halt_req,
  output logic        pc_sel,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halted,
  output logic [1:0]  state_o,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [SEQ_W-1:0] BOOT_INIT  = SEQ_W'(BOOT_CYCLES);
  localparam logic [SEQ_W-1:0] STALL_INIT = SEQ_W'(STALL_CYCLES - 1);
  // A zero boot hold skips BOOT entirely after release.
  localparam fstate_e RST_ST = (BOOT_CYCLES == 0) ? RUN : BOOT;

  fstate_e          state, state_nx;
  logic [SEQ_W-1:0] boot_cnt, boot_nx;
  logic [SEQ_W-1:0] stl_cnt, stl_nx;
  logic             stall_inc, flush_inc;
  ctl_t             ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RST_ST;
      boot_cnt <= BOOT_INIT;
      stl_cnt  <= '0;
    end else begin
      state    <= state_nx;
      boot_cnt <= boot_nx;
      stl_cnt  <= stl_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    boot_nx   = boot_cnt;
    stl_nx    = stl_cnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt <= SEQ_W'(1))
          state_nx = RUN;
        else
          boot_nx = boot_cnt - SEQ_W'(1);
      end
      RUN: begin
        if (branch_taken) begin
          flush_inc = 1'b1;
        end else if (load_use_hazard) begin
          stall_inc = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nx = STALL;
            stl_nx   = STALL_INIT;
          end
        end else if (halt_req) begin
          state_nx = HALT;
        end
      end
      STALL: begin
        if (branch_taken) begin
          flush_inc = 1'b1;
          state_nx  = RUN;
        end else begin
          stall_inc = 1'b1;
          if (stl_cnt <= SEQ_W'(1))
            state_nx = RUN;
          else
            stl_nx = stl_cnt - SEQ_W'(1);
        end
      end
      HALT: begin
        // A redirect while halted is taken but the halt persists.
        if (branch_taken)
          flush_inc = 1'b1;
        else if (!halt_req)
          state_nx = RUN;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_comb begin
    ctl = C_BOOT;
    if (!reset) begin
      case (state)
        BOOT:  ctl = C_BOOT;
        RUN: begin
          if (branch_taken)
            ctl = C_REDIR;
          else if (load_use_hazard)
            ctl = C_STALL;
          else
            ctl = C_FETCH;
        end
        STALL: ctl = branch_taken ? C_REDIR : C_STALL;
        HALT:  ctl = branch_taken ? C_REDIR : C_HALT;
        default: ctl = C_BOOT;
      endcase
    end
  end

  assign pc_sel      = ctl.pc_sel;
  assign pc_we       = ctl.pc_we;
  assign ifid_we     = ctl.ifid_we;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign halted      = (state == HALT);
  assign state_o     = state;

  if_ctrl_perf_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_inc & ~reset),
    .count (stall_count)
  );

  if_ctrl_perf_cnt u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_inc & ~reset),
    .count (flush_count)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a queue-based scoreboard.
// No ports.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic        load_use_hazard;
  logic        halt_req;
  logic        pc_sel, pc_we, ifid_we;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        halted;
  logic [1:0]  state_o;
  logic [31:0] stall_count, flush_count;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // {pc_sel, pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush}
  localparam logic [5:0] O_BOOT  = 6'b000111;
  localparam logic [5:0] O_FETCH = 6'b011000;
  localparam logic [5:0] O_REDIR = 6'b111111;
  localparam logic [5:0] O_STALL = 6'b000010;
  localparam logic [5:0] O_HALT  = 6'b000100;

  typedef struct packed {
    logic [1:0]  st;
    logic [5:0]  o;
    logic        hl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  if_fetch_ctrl #(
    .BOOT_CYCLES  (2),
    .STALL_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_taken    (branch_taken),
    .load_use_hazard (load_use_hazard),
    .halt_req        (halt_req),
    .pc_sel          (pc_sel),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .halted          (halted),
    .state_o         (state_o),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    exp_t       e;
    logic [5:0] o;
    e = sb.pop_front();
    o = {pc_sel, pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush};
    n_cmp++;
    assert (o === e.o) else begin
      n_bad++;
      $error("FAIL %s ctl obs=%b exp=%b", tag, o, e.o);
    end
    n_cmp++;
    assert (state_o === e.st) else begin
      n_bad++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, state_o, e.st);
    end
    n_cmp++;
    assert (halted === e.hl) else begin
      n_bad++;
      $error("FAIL %s halted obs=%b exp=%b", tag, halted, e.hl);
    end
    n_cmp++;
    assert (stall_count === e.sc) else begin
      n_bad++;
      $error("FAIL %s stall_count obs=%h exp=%h", tag, stall_count, e.sc);
    end
    n_cmp++;
    assert (flush_count === e.fc) else begin
      n_bad++;
      $error("FAIL %s flush_count obs=%h exp=%h", tag, flush_count, e.fc);
    end
  endtask

  // One cycle: drive, queue expectation, compare mid-cycle, advance model.
  task automatic cyc(input string tag,
                     input logic r, input logic b,
                     input logic l, input logic h,
                     input logic [1:0] es, input logic [5:0] eo,
                     input logic is_, input logic if_);
    exp_t e;
    @(negedge clk);
    reset           = r;
    branch_taken    = b;
    load_use_hazard = l;
    halt_req        = h;
    e.st = es;
    e.o  = eo;
    e.hl = (es == S_HALT);
    e.sc = m_stall;
    e.fc = m_flush;
    sb.push_back(e);
    #2;
    chk(tag);
    if (r) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall = m_stall + 32'(is_);
      m_flush = m_flush + 32'(if_);
    end
  endtask

  initial begin
    reset           = 1'b1;
    branch_taken    = 1'b0;
    load_use_hazard = 1'b0;
    halt_req        = 1'b0;
    @(posedge clk);

    cyc("rst0", 1, 0, 0, 0, S_BOOT, O_BOOT, 0, 0);
    cyc("rst1", 1, 0, 0, 0, S_BOOT, O_BOOT, 0, 0);
    cyc("rst2", 1, 0, 0, 0, S_BOOT, O_BOOT, 0, 0);
    cyc("boot0", 0, 0, 0, 0, S_BOOT, O_BOOT, 0, 0);
    cyc("boot1_ign", 0, 1, 1, 1, S_BOOT, O_BOOT, 0, 0);
    cyc("run0", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    cyc("redir", 0, 1, 0, 0, S_RUN, O_REDIR, 0, 1);
    cyc("post_redir", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    cyc("lu0", 0, 0, 1, 0, S_RUN, O_STALL, 1, 0);
    cyc("lu1", 0, 0, 0, 0, S_STALL, O_STALL, 1, 0);
    cyc("lu_done", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    cyc("br_lu", 0, 1, 1, 0, S_RUN, O_REDIR, 0, 1);
    cyc("lu2", 0, 0, 1, 0, S_RUN, O_STALL, 1, 0);
    cyc("br_stall", 0, 1, 1, 0, S_STALL, O_REDIR, 0, 1);
    cyc("after_bs", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    cyc("halt_req", 0, 0, 0, 1, S_RUN, O_FETCH, 0, 0);
    cyc("halt0", 0, 0, 0, 1, S_HALT, O_HALT, 0, 0);
    cyc("halt_br", 0, 1, 0, 1, S_HALT, O_REDIR, 0, 1);
    cyc("halt_lu", 0, 0, 1, 1, S_HALT, O_HALT, 0, 0);
    cyc("halt_rel", 0, 0, 0, 0, S_HALT, O_HALT, 0, 0);
    cyc("resume", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    cyc("lu3", 0, 0, 1, 0, S_RUN, O_STALL, 1, 0);
    cyc("rst_stall", 1, 0, 0, 0, S_STALL, O_BOOT, 0, 0);
    cyc("reboot0", 0, 0, 0, 0, S_BOOT, O_BOOT, 0, 0);
    cyc("reboot1", 0, 0, 0, 0, S_BOOT, O_BOOT, 0, 0);
    cyc("rerun", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    @(negedge clk);
    force dut.u_flush_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_flush_cnt.count;
    m_flush = 32'hFFFF_FFFF;
    cyc("wrap_br", 0, 1, 0, 0, S_RUN, O_REDIR, 0, 1);
    cyc("wrap_chk", 0, 0, 0, 0, S_RUN, O_FETCH, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
